// File: rtl/smart_house_cmd_tx.sv
// Serialises one of four fixed ASCII commands over a valid/ready character bus.
// Optional SMART_TX_CHECKSUM_EN appends the XOR of the command's characters.
module smart_house_cmd_tx #(
  parameter int         GAP_CYCLES = 0,
  parameter logic [7:0] FILL_CHAR  = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_start,
  input  logic [1:0] cmd_sel,
  input  logic       char_ready,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       busy,
  output logic       done
);

`ifdef SMART_TX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SEND, GAP, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SEND, GAP, DONE} state_t;
`endif

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] sel, sel_n;
  logic [3:0] idx, idx_n;
  logic [7:0] gap_cnt, gap_n;
  logic [7:0] out_n;
  logic       valid_n, busy_n, done_n;

  function automatic logic [7:0] rom(input logic [1:0] s,
                                     input logic [3:0] i);
    logic [7:0] c;
    case ({s, i})
      6'd0:  c = "O";
      6'd1:  c = "P";
      6'd2:  c = "E";
      6'd3:  c = "N";
      6'd4:  c = "W";
      6'd5:  c = "I";
      6'd6:  c = "N";
      6'd7:  c = "D";
      6'd8:  c = "O";
      6'd9:  c = "W";
      6'd16: c = "L";
      6'd17: c = "I";
      6'd18: c = "G";
      6'd19: c = "H";
      6'd20: c = "T";
      6'd21: c = "O";
      6'd22: c = "N";
      6'd32: c = "M";
      6'd33: c = "U";
      6'd34: c = "S";
      6'd35: c = "I";
      6'd36: c = "C";
      6'd37: c = "O";
      6'd38: c = "F";
      6'd39: c = "F";
      6'd48: c = "H";
      6'd49: c = "E";
      6'd50: c = "A";
      6'd51: c = "T";
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] s);
    logic [3:0] l;
    case (s)
      2'd0:    l = 4'd9;
      2'd1:    l = 4'd6;
      2'd2:    l = 4'd7;
      default: l = 4'd3;
    endcase
    return l;
  endfunction

`ifdef SMART_TX_CHECKSUM_EN
  logic csum_p, csum_p_n;

  function automatic logic [7:0] csum(input logic [1:0] s);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 16; k++)
      if (4'(k) <= last_idx(s)) x = x ^ rom(s, 4'(k));
    return x;
  endfunction
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= 2'd0;
      idx        <= 4'd0;
      gap_cnt    <= 8'd0;
      char_out   <= FILL_CHAR;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SMART_TX_CHECKSUM_EN
      csum_p     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      idx        <= idx_n;
      gap_cnt    <= gap_n;
      char_out   <= out_n;
      char_valid <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
`ifdef SMART_TX_CHECKSUM_EN
      csum_p     <= csum_p_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    idx_n   = idx;
    gap_n   = gap_cnt;
    out_n   = FILL_CHAR;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
`ifdef SMART_TX_CHECKSUM_EN
    csum_p_n = csum_p;
`endif
    unique case (state)
      IDLE: begin
        if (cmd_start) begin
          state_n = SEND;
          sel_n   = cmd_sel;
          idx_n   = 4'd0;
          out_n   = rom(cmd_sel, 4'd0);
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SEND: begin
        out_n   = char_out;
        valid_n = 1'b1;
        busy_n  = 1'b1;
        if (char_ready) begin
          if (idx == last_idx(sel)) begin
`ifdef SMART_TX_CHECKSUM_EN
            if (GAP_CYCLES > 0) begin
              state_n  = GAP;
              gap_n    = GAP_LOAD;
              out_n    = FILL_CHAR;
              valid_n  = 1'b0;
              csum_p_n = 1'b1;
            end else begin
              state_n = CSUM;
              out_n   = csum(sel);
            end
`else
            state_n = DONE;
            out_n   = FILL_CHAR;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
`endif
          end else begin
            idx_n = idx + 4'd1;
            if (GAP_CYCLES > 0) begin
              state_n = GAP;
              gap_n   = GAP_LOAD;
              out_n   = FILL_CHAR;
              valid_n = 1'b0;
            end else begin
              out_n = rom(sel, idx + 4'd1);
            end
          end
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == 8'd0) begin
          valid_n = 1'b1;
          state_n = SEND;
          out_n   = rom(sel, idx);
`ifdef SMART_TX_CHECKSUM_EN
          if (csum_p) begin
            state_n  = CSUM;
            out_n    = csum(sel);
            csum_p_n = 1'b0;
          end
`endif
        end else begin
          gap_n = gap_cnt - 8'd1;
        end
      end
`ifdef SMART_TX_CHECKSUM_EN
      CSUM: begin
        out_n   = char_out;
        valid_n = 1'b1;
        busy_n  = 1'b1;
        if (char_ready) begin
          state_n = DONE;
          out_n   = FILL_CHAR;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_smart_house_cmd_tx.sv
// Scoreboard bench: two transmitters (gap 0 and gap 2) share stimulus.
module tb_smart_house_cmd_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_start = 1'b0;
  logic [1:0] cmd_sel = 2'd0;
  logic       char_ready = 1'b0;
  logic [7:0] co [2];
  logic       cv [2];
  logic       bz [2];
  logic       dn [2];

  int passed = 0;
  int total  = 0;
  int ready_mode = 0;
  int done_cnt [2];
  int exp_q [2][$];
  logic       pv [2];
  logic       pr [2];
  logic [7:0] pc [2];
  int         run [2];
  bit         pend [2];
  string      cmds [4];

  localparam int DONE_TOK = 256;

  always #5 clock = ~clock;

  smart_house_cmd_tx #(.GAP_CYCLES(0), .FILL_CHAR(8'h00)) dut0 (
    .clock(clock), .reset(reset), .cmd_start(cmd_start),
    .cmd_sel(cmd_sel), .char_ready(char_ready),
    .char_out(co[0]), .char_valid(cv[0]), .busy(bz[0]), .done(dn[0])
  );

  smart_house_cmd_tx #(.GAP_CYCLES(2), .FILL_CHAR(8'h00)) dut1 (
    .clock(clock), .reset(reset), .cmd_start(cmd_start),
    .cmd_sel(cmd_sel), .char_ready(char_ready),
    .char_out(co[1]), .char_valid(cv[1]), .busy(bz[1]), .done(dn[1])
  );

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act == want) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
  endtask

  function automatic void push_cmd(input int s);
    int x;
    x = 0;
    for (int i = 0; i < cmds[s].len(); i++) begin
      int c;
      c = int'(cmds[s][i]);
      exp_q[0].push_back(c);
      exp_q[1].push_back(c);
      x = x ^ c;
    end
`ifdef SMART_TX_CHECKSUM_EN
    exp_q[0].push_back(x);
    exp_q[1].push_back(x);
`endif
    exp_q[0].push_back(DONE_TOK);
    exp_q[1].push_back(DONE_TOK);
  endfunction

  function automatic int pop(input int g);
    if (exp_q[g].size() == 0) return -1;
    return exp_q[g].pop_front();
  endfunction

  task automatic mon(input int g, input int gap);
    if (reset) begin
      pend[g] = 0;
      run[g]  = 0;
      pv[g]   = 0;
      return;
    end
    if (pv[g] && !pr[g]) begin
      chk($sformatf("hold_valid%0d", g), int'(cv[g]), 1);
      chk($sformatf("hold_char%0d", g), int'(co[g]), int'(pc[g]));
    end
    if (!cv[g]) chk($sformatf("fill%0d", g), int'(co[g]), 0);
    else chk($sformatf("busy_valid%0d", g), int'(bz[g]), 1);
    if (pend[g] && cv[g]) begin
      chk($sformatf("gap_len%0d", g), run[g], gap);
      pend[g] = 0;
    end
    if (dn[g]) begin
      chk($sformatf("done_tok%0d", g), pop(g), DONE_TOK);
      chk($sformatf("done_follows_last%0d", g), int'(pend[g]), 1);
      chk($sformatf("done_no_gap%0d", g), run[g], 0);
      chk($sformatf("done_busy%0d", g), int'(bz[g]), 0);
      done_cnt[g]++;
      pend[g] = 0;
    end
    if (!cv[g] && !dn[g]) run[g]++;
    if (cv[g] && char_ready) begin
      chk($sformatf("char%0d", g), int'(co[g]), pop(g));
      run[g]  = 0;
      pend[g] = 1;
    end
    pv[g] = cv[g];
    pr[g] = char_ready;
    pc[g] = co[g];
  endtask

  always @(negedge clock) begin
    mon(0, 0);
    mon(1, 2);
  end

  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       char_ready = 1'b1;
        1:       char_ready = 1'($urandom_range(0, 1));
        default: char_ready = (k % 4 == 3);
      endcase
      k++;
    end
  end

  task automatic run_cmd(input int s, input bit noise);
    int t, d0, d1;
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    @(posedge clock);
    #1;
    cmd_sel   = 2'(s);
    cmd_start = 1'b1;
    push_cmd(s);
    @(posedge clock);
    #1;
    cmd_start = 1'b0;
    if (noise) cmd_sel = 2'($urandom);
    @(negedge clock);
    chk("latency_valid0", int'(cv[0]), 1);
    chk("latency_valid1", int'(cv[1]), 1);
    chk("latency_busy0", int'(bz[0]), 1);
    chk("latency_busy1", int'(bz[1]), 1);
    if (noise) begin
      @(posedge clock);
      #1;
      cmd_start = 1'b1;
      cmd_sel   = 2'($urandom);
      @(posedge clock);
      #1;
      cmd_start = 1'b0;
      cmd_sel   = 2'($urandom);
    end
    t = 0;
    while ((done_cnt[0] == d0 || done_cnt[1] == d1) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk("cmd_completed", int'(t < 3000), 1);
    chk("queue_empty0", exp_q[0].size(), 0);
    chk("queue_empty1", exp_q[1].size(), 0);
    exp_q[0].delete();
    exp_q[1].delete();
  endtask

  initial begin
    cmds[0] = "OPENWINDOW";
    cmds[1] = "LIGHTON";
    cmds[2] = "MUSICOFF";
    cmds[3] = "HEAT";
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    for (int g = 0; g < 2; g++) begin
      chk("rst_valid", int'(cv[g]), 0);
      chk("rst_busy", int'(bz[g]), 0);
      chk("rst_done", int'(dn[g]), 0);
      chk("rst_char", int'(co[g]), 0);
    end

    ready_mode = 0;
    run_cmd(0, 0);
    ready_mode = 2;
    run_cmd(3, 0);
    ready_mode = 0;
    run_cmd(1, 0);
    run_cmd(0, 1);

    // abort OPENWINDOW after its fourth transfer
    @(posedge clock);
    #1;
    cmd_sel   = 2'd0;
    cmd_start = 1'b1;
    push_cmd(0);
    @(posedge clock);
    #1;
    cmd_start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clock);
    for (int g = 0; g < 2; g++) begin
      chk("abort_valid", int'(cv[g]), 0);
      chk("abort_busy", int'(bz[g]), 0);
      chk("abort_done", int'(dn[g]), 0);
    end
    repeat (6) @(negedge clock);
    run_cmd(0, 0);

    for (int n = 0; n < 30; n++) begin
      ready_mode = $urandom_range(0, 2);
      run_cmd($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
